// File: rtl/base_string_to_decimal_pkg.sv
// Shared types and constants for the base-N ASCII string to binary converter.
package base_conv_pkg;

    localparam int unsigned BASE_W = 5;
    localparam int unsigned CHAR_W = 8;
    localparam int unsigned ERR_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [ERR_W-1:0] ERR_BASE  = 3'b001;
    localparam logic [ERR_W-1:0] ERR_DIGIT = 3'b010;
    localparam logic [ERR_W-1:0] ERR_OVF   = 3'b100;
    localparam logic [ERR_W-1:0] ERR_EMPTY = 3'b111;

    localparam logic [CHAR_W-1:0] ASC_0   = 8'h30;
    localparam logic [CHAR_W-1:0] ASC_9   = 8'h39;
    localparam logic [CHAR_W-1:0] ASC_A   = 8'h41;
    localparam logic [CHAR_W-1:0] ASC_F   = 8'h46;
    localparam logic [CHAR_W-1:0] ASC_LA  = 8'h61;
    localparam logic [CHAR_W-1:0] ASC_LF  = 8'h66;
    localparam logic [CHAR_W-1:0] ASC_SP  = 8'h20;
    localparam logic [CHAR_W-1:0] ASC_NUL = 8'h00;

    localparam logic [BASE_W-1:0] BASE_MIN = 5'd2;
    localparam logic [BASE_W-1:0] BASE_MAX = 5'd16;

endpackage

// File: rtl/base_string_to_decimal_if.sv
// Character-in / result-out valid-ready bundle for the string converter.
interface base_string_to_decimal_if #(
    parameter int unsigned VALUE_W = 32
);
    import base_conv_pkg::*;

    logic [BASE_W-1:0]  base;
    logic               in_valid;
    logic               in_ready;
    logic [CHAR_W-1:0]  in_char;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [VALUE_W-1:0] out_value;
    logic [ERR_W-1:0]   out_err;

    modport master (
        output base, in_valid, in_char, in_last, out_ready,
        input  in_ready, out_valid, out_value, out_err
    );

    modport slave (
        input  base, in_valid, in_char, in_last, out_ready,
        output in_ready, out_valid, out_value, out_err
    );

endinterface

// File: rtl/base_string_to_decimal_decode.sv
// Combinational ASCII classifier: hex digit value, padding flag, digit flag.
module ascii_digit_decode
    import base_conv_pkg::*;
(
    input  logic [CHAR_W-1:0] char_i,
    output logic              is_digit_c,
    output logic              is_pad_c,
    output logic [3:0]        digit_c
);

    always_comb begin
        is_digit_c = 1'b0;
        is_pad_c   = 1'b0;
        digit_c    = 4'd0;
        if (char_i >= ASC_0 && char_i <= ASC_9) begin
            is_digit_c = 1'b1;
            digit_c    = 4'(char_i - ASC_0);
        end else if (char_i >= ASC_A && char_i <= ASC_F) begin
            is_digit_c = 1'b1;
            digit_c    = 4'(char_i - ASC_A + 8'd10);
        end else if (char_i >= ASC_LA && char_i <= ASC_LF) begin
            is_digit_c = 1'b1;
            digit_c    = 4'(char_i - ASC_LA + 8'd10);
        end else if (char_i == ASC_SP || char_i == ASC_NUL) begin
            is_pad_c = 1'b1;
        end
    end

endmodule

// File: rtl/base_string_to_decimal.sv
// Accumulates an MSB-first ASCII digit string in base 2..16 into an unsigned binary value.
module base_string_to_decimal
    import base_conv_pkg::*;
#(
    parameter int unsigned VALUE_W   = 32,
    parameter int unsigned MAX_CHARS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    base_string_to_decimal_if.slave  bus
);

    localparam int unsigned ACC_W = VALUE_W + 5;
    localparam int unsigned CNT_W = $clog2(MAX_CHARS + 1);

    state_e             state_q, state_d;
    logic [BASE_W-1:0]  base_q, base_d;
    logic [VALUE_W-1:0] acc_q, acc_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               seen_q, seen_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [VALUE_W-1:0] out_value_q, out_value_d;
    logic [ERR_W-1:0]   out_err_q, out_err_d;

    logic               is_digit, is_pad;
    logic [3:0]         digit;
    logic               accept;
    logic [BASE_W-1:0]  base_cur;
    logic [VALUE_W-1:0] acc_cur;
    logic [ERR_W-1:0]   err_cur;
    logic [CNT_W-1:0]   cnt_cur;
    logic               seen_cur;
    logic [ACC_W-1:0]   prod;

    ascii_digit_decode u_decode (
        .char_i     (bus.in_char),
        .is_digit_c (is_digit),
        .is_pad_c   (is_pad),
        .digit_c    (digit)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_value = out_value_q;
    assign bus.out_err   = out_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            acc_q       <= '0;
            err_q       <= '0;
            cnt_q       <= '0;
            seen_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            out_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            out_err_q   <= out_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        acc_d       = acc_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        seen_d      = seen_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        out_err_d   = out_err_q;

        accept   = bus.in_valid & in_ready_q;
        base_cur = base_q;
        acc_cur  = acc_q;
        err_cur  = err_q;
        cnt_cur  = cnt_q;
        seen_cur = seen_q;

        // The first char of a string starts from a clean context with the live base.
        if (state_q == IDLE) begin
            base_cur = bus.base;
            acc_cur  = '0;
            err_cur  = (bus.base < BASE_MIN || bus.base > BASE_MAX) ? ERR_BASE : '0;
            cnt_cur  = '0;
            seen_cur = 1'b0;
        end

        prod = ACC_W'(acc_cur) * ACC_W'(base_cur) + ACC_W'(digit);

        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    base_d = base_cur;
                    acc_d  = acc_cur;
                    err_d  = err_cur;
                    cnt_d  = cnt_cur;
                    seen_d = seen_cur;
                    if (!is_pad) begin
                        seen_d = 1'b1;
                        // Errors are sticky: later chars only drain.
                        if (err_cur == '0) begin
                            if (!is_digit || {1'b0, digit} >= base_cur) begin
                                err_d = ERR_DIGIT;
                            end else if (cnt_cur == CNT_W'(MAX_CHARS)) begin
                                err_d = ERR_OVF;
                            end else if (prod[ACC_W-1:VALUE_W] != '0) begin
                                err_d = ERR_OVF;
                            end else begin
                                acc_d = prod[VALUE_W-1:0];
                                cnt_d = cnt_cur + CNT_W'(1);
                            end
                        end
                    end
                    if (bus.in_last) begin
                        state_d     = DONE;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                        if (!seen_d && err_d == '0) begin
                            out_err_d   = ERR_EMPTY;
                            out_value_d = '0;
                        end else begin
                            out_err_d   = err_d;
                            out_value_d = (err_d == '0) ? acc_d : '0;
                        end
                    end else begin
                        state_d = ACCUM;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_base_string_to_decimal.sv
// Randomized and directed bench for base_string_to_decimal with a string-level reference model.
module tb_base_string_to_decimal;

    typedef byte unsigned bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    base_string_to_decimal_if #(.VALUE_W(32)) bus ();

    base_string_to_decimal #(.VALUE_W(32), .MAX_CHARS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int digval(input byte unsigned c);
        if (c >= "0" && c <= "9") return int'(c) - int'("0");
        if (c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
        if (c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
        return -1;
    endfunction

    // Reference: first error wins, returns {err, value}.
    function automatic logic [34:0] model(input bq_t q, input int b);
        longint unsigned v = 0;
        int n = 0;
        bit seen = 0;
        int d;
        if (b < 2 || b > 16) return {3'b001, 32'd0};
        foreach (q[i]) begin
            if (q[i] == 8'h20 || q[i] == 8'h00) continue;
            seen = 1;
            d = digval(q[i]);
            if (d < 0 || d >= b) return {3'b010, 32'd0};
            n++;
            if (n > 16) return {3'b100, 32'd0};
            v = v * longint'(b) + longint'(d);
            if (v > 64'hFFFF_FFFF) return {3'b100, 32'd0};
        end
        if (!seen) return {3'b111, 32'd0};
        return {3'b000, v[31:0]};
    endfunction

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic run(input string tag, input bq_t q, input int b, input int hold);
        logic [34:0] exp;
        logic [31:0] v0;
        int t;
        exp = model(q, b);
        bus.out_ready = (hold == 0);
        foreach (q[i]) begin
            if ($urandom_range(3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_char  = q[i];
            bus.in_last  = (i == q.size() - 1);
            bus.base     = (i == 0) ? 5'(b) : 5'($urandom);
            t = 0;
            while (!bus.in_ready && t < 100) begin
                @(posedge clk); #1;
                t++;
            end
            if (t >= 100) begin
                chk({tag, "/in_timeout"}, 64'(bus.in_ready), 64'd1);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk({tag, "/valid_lat"}, 64'(bus.out_valid), 64'd1);
        chk({tag, "/ready_done"}, 64'(bus.in_ready), 64'd0);
        chk({tag, "/value"}, 64'(bus.out_value), 64'(exp[31:0]));
        chk({tag, "/err"}, 64'(bus.out_err), 64'(exp[34:32]));
        v0 = exp[31:0];
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk({tag, "/hold_valid"}, 64'(bus.out_valid), 64'd1);
            chk({tag, "/hold_value"}, 64'(bus.out_value), 64'(v0));
            chk({tag, "/hold_ready"}, 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "/drop_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "/ready_back"}, 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "/in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "/out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "/out_value"}, 64'(bus.out_value), 64'd0);
        chk({tag, "/out_err"}, 64'(bus.out_err), 64'd0);
    endtask

    function automatic byte unsigned dchar(input int d);
        if (d < 10) return 8'(int'("0") + d);
        return ($urandom_range(1) == 1) ? 8'(int'("A") + d - 10) : 8'(int'("a") + d - 10);
    endfunction

    initial begin
        bq_t q;
        int b, len, r;
        bus.base      = 5'd10;
        bus.in_valid  = 1'b0;
        bus.in_char   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        chk_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        run("b2_1010", s2q("1010"), 2, 0);
        run("h_FF", s2q("FF"), 16, 1);
        run("h_ff", s2q("ff"), 16, 0);
        run("o_144", s2q("144"), 8, 2);
        run("d_500", s2q("500"), 10, 0);
        run("badbase", s2q("50"), 1, 0);
        run("o_9", s2q("9"), 8, 0);
        run("h_G", s2q("G"), 16, 0);
        run("d_max", s2q("4294967295"), 10, 0);
        run("d_ovf", s2q("4294967296"), 10, 0);
        run("pad0", s2q("  0"), 2, 0);
        run("empty", s2q("   "), 10, 0);
        run("lead0", s2q("0010"), 2, 0);
        run("b2_16ch", s2q("1111111111111111"), 2, 0);
        run("b2_17ch", s2q("11111111111111111"), 2, 0);
        run("h_32b", s2q("FFFFFFFF"), 16, 0);
        run("h_33b", s2q("100000000"), 16, 0);
        run("hold5", s2q("7B"), 16, 5);

        // Abort mid-string with an asynchronous reset.
        bus.base     = 5'd10;
        bus.in_valid = 1'b1;
        bus.in_char  = "1";
        bus.in_last  = 1'b0;
        @(posedge clk); #1;
        bus.in_char = "2";
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk_reset_vals("midrst");
        rst = 1'b0;
        @(posedge clk); #1;
        run("after_rst", s2q("7"), 10, 0);

        for (int n = 0; n < 200; n++) begin
            q.delete();
            b   = ($urandom_range(9) == 0) ? int'($urandom_range(31)) : int'($urandom_range(16, 2));
            len = int'($urandom_range(18, 1));
            for (int i = 0; i < len; i++) begin
                r = int'($urandom_range(19));
                if (r == 0) q.push_back(($urandom_range(1) == 1) ? 8'h20 : 8'h00);
                else if (r == 1) q.push_back(8'($urandom));
                else if (b >= 2 && b <= 16) q.push_back(dchar(int'($urandom_range(b - 1))));
                else q.push_back(dchar(int'($urandom_range(15))));
            end
            run("rand", q, b, int'($urandom_range(3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
